// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one multiplier-accumulator walks all ORDER+1 taps per sample,
// with a circular sample history and a run-time-writable coefficient bank.
module fir_mac_sequencer #(
  parameter int IN_DATAWIDTH = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int ORDER        = 8,
  parameter int OUT_SHIFT    = 4,
  parameter int OUT_WIDTH    = 40
) (
  input  logic                    sclk,
  input  logic                    s_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_DATAWIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  input  logic                    coef_we,
  input  logic [3:0]              coef_addr,
  input  logic [COEFF_WIDTH-1:0]  coef_wdata,
  output logic                    coef_err
);

  localparam int N      = ORDER + 1;
  localparam int PW     = (N > 1) ? $clog2(N + 1) : 1;
  localparam int PROD_W = IN_DATAWIDTH + COEFF_WIDTH;
  localparam logic [PW-1:0] LAST_IDX = PW'(ORDER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Power-on coefficient set (symmetric low-pass taps)
  function automatic logic [COEFF_WIDTH-1:0] coef_default(input int idx);
    case (idx)
      32'sd0:  coef_default = COEFF_WIDTH'(16'd627);
      32'sd1:  coef_default = COEFF_WIDTH'(16'd539);
      32'sd2:  coef_default = COEFF_WIDTH'(16'd683);
      32'sd3:  coef_default = COEFF_WIDTH'(16'd782);
      32'sd4:  coef_default = COEFF_WIDTH'(16'd818);
      32'sd5:  coef_default = COEFF_WIDTH'(16'd782);
      32'sd6:  coef_default = COEFF_WIDTH'(16'd683);
      32'sd7:  coef_default = COEFF_WIDTH'(16'd539);
      32'sd8:  coef_default = COEFF_WIDTH'(16'd627);
      default: coef_default = '0;
    endcase
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IN_DATAWIDTH-1:0] hist_r [N];
  logic [COEFF_WIDTH-1:0]  coef_r [N];
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [PW-1:0]           k_r;
  logic [OUT_WIDTH-1:0]    acc_r;
  logic [OUT_WIDTH-1:0]    out_data_r;
  logic                    out_valid_r;
  logic                    in_ready_r;
  logic                    coef_err_r;

  logic                    accept_s;
  logic                    mac_s;
  logic                    last_s;
  logic                    coef_ok_s;
  logic                    coef_bad_s;
  logic [PROD_W-1:0]       prod_s;
  logic [OUT_WIDTH-1:0]    acc_sum_s;

  // State register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid && in_ready_r) begin
          state_nxt_s = S_MAC;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MAC: begin
        if (k_r == LAST_IDX) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_MAC;
        end
      end
      S_DONE: begin
        if (out_valid_r && out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Per-state control strobes and the shared MAC datapath
  always_comb begin
    accept_s   = (state_r == S_IDLE) && in_valid && in_ready_r;
    mac_s      = (state_r == S_MAC);
    last_s     = mac_s && (k_r == LAST_IDX);
    coef_ok_s  = coef_we && (state_r == S_IDLE) && (coef_addr <= 4'(ORDER));
    coef_bad_s = coef_we && !coef_ok_s;
    prod_s     = PROD_W'(coef_r[k_r]) * PROD_W'(hist_r[rd_ptr_r]);
    acc_sum_s  = acc_r + OUT_WIDTH'(prod_s);
  end

  // Datapath registers: history, coefficients, pointers, accumulator, outputs
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int i = 0; i < N; i++) begin
        hist_r[i] <= '0;
        coef_r[i] <= coef_default(i);
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      coef_err_r  <= 1'b0;
    end else begin
      // A same-edge write lands before the MAC reads the bank, so a new sample sees it
      if (coef_ok_s) begin
        coef_r[coef_addr] <= coef_wdata;
      end
      coef_err_r <= coef_bad_s;
      if (accept_s) begin
        hist_r[wr_ptr_r] <= in_data;
        rd_ptr_r         <= wr_ptr_r;
        wr_ptr_r         <= (wr_ptr_r == LAST_IDX) ? '0 : wr_ptr_r + PW'(1);
        acc_r            <= '0;
        k_r              <= '0;
      end else if (mac_s) begin
        acc_r    <= acc_sum_s;
        k_r      <= k_r + PW'(1);
        rd_ptr_r <= (rd_ptr_r == '0) ? LAST_IDX : rd_ptr_r - PW'(1);
        if (last_s) begin
          out_data_r <= acc_sum_s << OUT_SHIFT;
        end
      end
      out_valid_r <= (state_nxt_s == S_DONE);
      in_ready_r  <= (state_nxt_s == S_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign coef_err  = coef_err_r;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed plus randomized bench for fir_mac_sequencer against a direct-form
// shift-register reference model.
module tb_fir_mac_sequencer;

  localparam int N = 9;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_data;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        coef_err;

  int checks = 0;
  int errors = 0;

  longint unsigned m_coef [N];
  longint unsigned m_hist [N];
  logic [39:0]     exp_q  [$];
  logic [39:0]     last_exp;

  localparam longint unsigned DEF_COEF [N] = '{627, 539, 683, 782, 818, 782, 683, 539, 627};
  localparam longint unsigned IMPULSE  [N] = '{10032, 8624, 10928, 12512, 13088, 12512, 10928, 8624, 10032};

  always #5 sclk = ~sclk;

  fir_mac_sequencer dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err)
  );

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_coef[i] = DEF_COEF[i];
      m_hist[i] = 64'd0;
    end
  endfunction

  // Direct form: m_hist[0] is the newest sample x[n]
  function automatic logic [39:0] model_push(input logic [15:0] x);
    longint unsigned sum;
    for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = 64'(x);
    sum = 64'd0;
    for (int i = 0; i < N; i++) sum += m_coef[i] * m_hist[i];
    return 40'(sum * 64'd16);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    s_rst_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'd0;
    out_ready  = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = 4'd0;
    coef_wdata = 16'd0;
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;
    model_reset();
    @(negedge sclk);
  endtask

  // Called at the negedge right after the accept edge (lat = cycles since accept)
  task automatic wait_result(input int start_lat, input logic [39:0] exp, input bit rdy);
    int lat;
    lat = start_lat;
    out_ready = rdy;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge sclk);
      lat++;
    end
    check("latency", 64'(lat), 64'd9);
    check("out_data", 64'(out_data), 64'(exp));
    if (rdy) begin
      @(negedge sclk);
      check("out_valid_drop", 64'(out_valid), 64'd0);
      check("in_ready_back", 64'(in_ready), 64'd1);
    end
  endtask

  task automatic accept(input logic [15:0] x);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge sclk);
      w++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(negedge sclk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    last_exp = model_push(x);
  endtask

  task automatic send(input logic [15:0] x, input bit rdy, output logic [39:0] got);
    accept(x);
    wait_result(0, last_exp, rdy);
    got = out_data_snapshot;
  endtask

  logic [39:0] out_data_snapshot;
  always @(posedge out_valid) out_data_snapshot = out_data;

  task automatic impulse_run(input string tag);
    logic [39:0] got;
    for (int i = 0; i < N; i++) begin
      send((i == 0) ? 16'd1 : 16'd0, 1'b1, got);
      check(tag, 64'(got), IMPULSE[i]);
    end
  endtask

  task automatic bad_write(input logic [3:0] addr, input logic [15:0] data);
    coef_we    = 1'b1;
    coef_addr  = addr;
    coef_wdata = data;
    @(negedge sclk);
    coef_we = 1'b0;
    check("coef_err_pulse", 64'(coef_err), 64'd1);
    @(negedge sclk);
    check("coef_err_clear", 64'(coef_err), 64'd0);
  endtask

  initial begin
    logic [39:0] got;
    int acc_cnt, out_cnt, cyc;

    // Reset state
    do_reset();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_coef_err", 64'(coef_err), 64'd0);

    impulse_run("impulse");

    // Constant inputs
    for (int i = 0; i < 10; i++) begin
      send(16'd1, 1'b1, got);
      if (i >= 8) check("const1", 64'(got), 64'd97280);
    end
    for (int i = 0; i < N; i++) send(16'd65535, 1'b1, got);
    check("const_max", 64'(got), 64'd6375244800);

    // Backpressure, with an ignored sample offer and a rejected write in DONE
    send(16'd300, 1'b0, got);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd7;
      coef_we    = (i == 0);
      coef_addr  = 4'd2;
      coef_wdata = 16'd9;
      @(negedge sclk);
      coef_we = 1'b0;
      if (i == 0) check("done_coef_err", 64'(coef_err), 64'd1);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_data", 64'(out_data), 64'(last_exp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge sclk);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);

    // Flush history, then an accepted coefficient write
    for (int i = 0; i < N - 1; i++) send(16'd0, 1'b1, got);
    coef_we    = 1'b1;
    coef_addr  = 4'd0;
    coef_wdata = 16'd1000;
    @(negedge sclk);
    coef_we   = 1'b0;
    m_coef[0] = 64'd1000;
    check("good_write_err", 64'(coef_err), 64'd0);
    send(16'd1, 1'b1, got);
    check("coef0_1000", 64'(got), 64'd16000);

    // Write during MAC is rejected
    accept(16'd5);
    repeat (2) @(negedge sclk);
    bad_write(4'd1, 16'd5);
    wait_result(4, last_exp, 1'b1);
    // Out-of-range write is rejected
    bad_write(4'd9, 16'd1234);
    for (int i = 0; i < N; i++) send((i == 0) ? 16'd1 : 16'd0, 1'b1, got);

    // Reset mid-MAC at k=4
    accept(16'd1);
    repeat (4) @(negedge sclk);
    s_rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_data", 64'(out_data), 64'd0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    model_reset();
    @(negedge sclk);
    impulse_run("impulse_after_rst");

    // Write and accept on the same edge: the sample sees the new coefficient
    coef_we    = 1'b1;
    coef_addr  = 4'd0;
    coef_wdata = 16'd2000;
    m_coef[0]  = 64'd2000;
    send(16'd3, 1'b1, got);

    // Random traffic with random backpressure
    acc_cnt = 0;
    out_cnt = 0;
    cyc     = 0;
    while ((acc_cnt < 500 || exp_q.size() > 0) && cyc < 20000) begin
      in_valid  = (acc_cnt < 500) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(model_push(in_data));
        acc_cnt++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious_valid", 64'(out_valid), 64'd0);
        end else if (out_ready) begin
          check("rand_out", 64'(out_data), 64'(exp_q.pop_front()));
          out_cnt++;
        end
      end
      @(negedge sclk);
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_timeout", 64'(cyc < 20000), 64'd1);
    check("rand_count", 64'(out_cnt), 64'd500);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed 9-tap FIR engine: one shared multiplier-accumulator is sequenced across all taps for each input sample, trading throughput for area against the fully parallel direct-form filter. It owns a circular sample-history buffer and a run-time-writable coefficient bank, and it accepts samples and returns results over valid/ready handshakes. It sits between the ADC sample stream and downstream processing wherever the sample rate is at most sclk/11.

## Interface
- IN_DATAWIDTH, 16, input sample width (unsigned)
- COEFF_WIDTH, 16, coefficient width (unsigned)
- ORDER, 8, filter order; tap count N = ORDER+1
- OUT_SHIFT, 4, left shift applied to the final accumulator
- OUT_WIDTH, 40, output width; holds the full sum plus the shift without truncation
- sclk  in  1  clock
- s_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample offered
- in_ready  out  1  high only in IDLE
- in_data  in  IN_DATAWIDTH  sample
- out_valid  out  1  result available; held until accepted
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_WIDTH  filtered result
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  tap index 0..ORDER
- coef_wdata  in  COEFF_WIDTH  coefficient value
- coef_err  out  1  one-cycle pulse when a write is rejected

## Operation
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; coef_err=0; history all 0; wr_ptr=0.
- Coefficient reset values for taps 0..8: 627, 539, 683, 782, 818, 782, 683, 539, 627.
- Result: y = (sum over k=0..ORDER of coef[k]*x[n-k]) << OUT_SHIFT, unsigned, zero-extended to OUT_WIDTH.
- Product width is IN_DATAWIDTH+COEFF_WIDTH. The accumulator is OUT_WIDTH wide; no saturation is applied.
- IDLE:
  - On in_valid&&in_ready, write in_data to hist[wr_ptr], set rd_ptr=wr_ptr, clear acc, set k=0, and go to MAC.
  - wr_ptr advances modulo N, wrapping ORDER to 0.
- MAC: each cycle, acc += coef[k]*hist[rd_ptr]; k++; rd_ptr decrements modulo N, wrapping 0 to ORDER.
  - After the k=ORDER accumulation, load out_data=acc<<OUT_SHIFT, assert out_valid, and go to DONE.
- DONE: hold out_data and out_valid. On out_valid&&out_ready, drop out_valid and return to IDLE.
- in_ready is 0 in MAC and DONE. in_valid in those states is ignored, and the sample is not consumed.
- Coefficient writes:
  - A write is accepted only in IDLE with coef_addr<=ORDER; coef[addr] updates on that edge.
  - A write attempted in MAC or DONE, or with coef_addr>ORDER, changes nothing and pulses coef_err for one cycle.
- Simultaneous coefficient write and sample accept in IDLE: the write lands first, and the new sample uses the new coefficient.
- Reset asserted mid-MAC or mid-DONE: abort immediately to the reset values above. The result is lost and coefficients revert to their defaults.
- The first N-1 outputs after reset use zero history, matching a shift register cleared to zero.

## Timing
- Accept edge = E0. MAC edges E1..E(N). out_valid is high from E(N), so it is first visible N cycles after acceptance (9 at default).
- With out_ready held high, the handshake happens at E(N+1) and in_ready is high again after E(N+1). The next accept is at E(N+2) at the earliest, so the minimum sample period is N+2 = 11 cycles.
- out_data is registered and stable for the whole time out_valid is high.
- coef_err is registered and asserts the cycle after the offending strobe.

## Test plan
- Reset, then impulse 1 followed by 8 zeros, out_ready=1. Outputs in order: 10032, 8624, 10928, 12512, 13088, 12512, 10928, 8624, 10032. Each appears 9 cycles after its accept.
- Constant 1 for 10 samples: the 9th and 10th outputs are 97280 (6080<<4). Constant 65535: steady output is 6375244800, with no wrap at OUT_WIDTH=40.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. out_data stays stable, in_ready stays 0, and an offered in_valid is not consumed. Raise out_ready: handshake, then IDLE.
- Write coef[0]=1000 in IDLE, then send impulse 1: first output is 16000. Write during MAC, or to addr 9: coef_err pulses, and the coefficient bank is unchanged (verify with a subsequent impulse).
- Assert s_rst_n=0 at MAC k=4: out_valid=0, in_ready=1, and coefficients are back to defaults. Re-run the impulse test and get identical results.
- Random back-to-back stimulus (500 samples, random in_valid/out_ready) against a direct-form reference model: every output matches, with no drops and no duplicates.
